cacheline_arbiter: RTL and testbench

- Shares the single 256-bit physical-memory port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two cache instances' pmem_* interfaces and main memory.
- Serialises one cacheline transaction at a time and breaks simultaneous-request ties with round-robin.
- Latches the winning request so the memory-side signals stay stable for the whole transaction.

---
 rtl/cacheline_arbiter.sv | 116 +++++++++++
 tb/tb_cacheline_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_arbiter.sv
// Two-requester cacheline arbiter: shares one physical-memory port between the
// I-cache (read only) and the D-cache (read/write), one line transaction at a time.
module cacheline_arbiter #(
  parameter int s_line = 256,
  parameter int s_addr = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [s_addr-1:0] i_pmem_address,
  input  logic              i_pmem_read,
  output logic [s_line-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic [s_addr-1:0] d_pmem_address,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [s_line-1:0] d_pmem_wdata,
  output logic [s_line-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic [s_addr-1:0] pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  // Handshake: a requester holds its strobe until it sees its own resp for one
  // cycle; memory holds nothing of ours except the latched request, and a
  // single-cycle pmem_resp ends the transaction.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RECOVER = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              last_d_q, last_d_d;
  logic [s_addr-1:0] addr_q, addr_d;
  logic [s_line-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              d_req;

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  always_comb begin
    state_d      = state_q;
    last_d_d     = last_d_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    d_req        = d_pmem_read | d_pmem_write;

    unique case (state_q)
      IDLE: begin
        // On a tie the requester that was not served last wins.
        if (i_pmem_read && (!d_req || last_d_q)) begin
          state_d  = SERVE_I;
          addr_d   = i_pmem_address;
          wdata_d  = '0;
          wr_d     = 1'b0;
          last_d_d = 1'b0;
        end else if (d_req) begin
          state_d  = SERVE_D;
          addr_d   = d_pmem_address;
          wdata_d  = d_pmem_wdata;
          wr_d     = d_pmem_write;
          last_d_d = 1'b1;
        end
      end
      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = addr_q;
        i_pmem_resp  = pmem_resp;
        if (pmem_resp) state_d = RECOVER;
      end
      SERVE_D: begin
        pmem_read    = ~wr_q;
        pmem_write   = wr_q;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        d_pmem_resp  = pmem_resp;
        if (pmem_resp) state_d = RECOVER;
      end
      RECOVER: begin
        // Lets the served requester drop its strobe before arbitration resumes.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
    end
  end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed bench for cacheline_arbiter: transaction-level model checked every
// cycle, plus literal expectations per scenario.
module tb_cacheline_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk, rst;
  logic [AW-1:0] i_addr, d_addr, pmem_address;
  logic          i_read, d_read, d_write;
  logic [LW-1:0] d_wdata, i_rdata, d_rdata, pmem_wdata, pmem_rdata;
  logic          i_resp, d_resp, pmem_read, pmem_write, pmem_resp;

  cacheline_arbiter #(.s_line(LW), .s_addr(AW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_address(i_addr), .i_pmem_read(i_read),
    .i_pmem_rdata(i_rdata), .i_pmem_resp(i_resp),
    .d_pmem_address(d_addr), .d_pmem_read(d_read), .d_pmem_write(d_write),
    .d_pmem_wdata(d_wdata), .d_pmem_rdata(d_rdata), .d_pmem_resp(d_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [LW-1:0] exp_q[$];
  int resp_order[$];
  int rd_cycles, wr_cycles, i_resp_cnt, d_resp_cnt;
  logic [AW-1:0] seen_addr;
  logic [LW-1:0] seen_wdata, cap_rdata;

  // model: owner 0 = nobody, 1 = I-cache, 2 = D-cache
  int            m_owner;
  bit            m_recover, m_last_d, m_wr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  bit            model_ok = 1'b0;

  task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin : model_upd
    bit i_req, d_req;
    i_req = i_read;
    d_req = d_read | d_write;
    if (rst) begin
      m_owner = 0; m_recover = 1'b0; m_last_d = 1'b0;
      m_addr = '0; m_wdata = '0; m_wr = 1'b0; model_ok = 1'b1;
    end else if (model_ok) begin
      if (m_owner != 0) begin
        if (pmem_resp) begin
          m_owner = 0;
          m_recover = 1'b1;
        end
      end else if (m_recover) begin
        m_recover = 1'b0;
      end else if (i_req || d_req) begin
        if (i_req && d_req) m_owner = m_last_d ? 1 : 2;
        else m_owner = i_req ? 1 : 2;
        m_last_d = (m_owner == 2);
        if (m_owner == 1) begin
          m_addr = i_addr;
        end else begin
          m_addr = d_addr; m_wdata = d_wdata; m_wr = d_write;
        end
      end
    end
  end

  // scoreboard: compare every cycle, away from the active edge
  always begin : cmp
    logic exp_rd, exp_wr;
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_wdata;
    @(negedge clk);
    #2;
    if (model_ok) begin
      exp_rd    = (m_owner == 1) || (m_owner == 2 && !m_wr);
      exp_wr    = (m_owner == 2) && m_wr;
      exp_addr  = (m_owner != 0) ? m_addr : '0;
      exp_wdata = (m_owner == 2) ? m_wdata : '0;
      check("cyc_pmem_read", LW'(pmem_read), LW'(exp_rd));
      check("cyc_pmem_write", LW'(pmem_write), LW'(exp_wr));
      check("cyc_pmem_address", LW'(pmem_address), LW'(exp_addr));
      check("cyc_pmem_wdata", pmem_wdata, exp_wdata);
      check("cyc_i_resp", LW'(i_resp), LW'((m_owner == 1) && pmem_resp));
      check("cyc_d_resp", LW'(d_resp), LW'((m_owner == 2) && pmem_resp));
      check("cyc_i_rdata", i_rdata, pmem_rdata);
      check("cyc_d_rdata", d_rdata, pmem_rdata);
      check("cyc_excl", LW'((i_resp & d_resp) | (pmem_read & pmem_write)), '0);
      if (pmem_read) rd_cycles++;
      if (pmem_write) begin
        wr_cycles++;
        seen_wdata = pmem_wdata;
      end
      if (pmem_read || pmem_write) seen_addr = pmem_address;
      if (i_resp) i_resp_cnt++;
      if (d_resp) d_resp_cnt++;
      if (i_resp || d_resp) begin
        resp_order.push_back(i_resp ? 1 : 2);
        cap_rdata = i_resp ? i_rdata : d_rdata;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL resp_rdata: resp with no outstanding memory data, required none");
        end else begin
          check("resp_rdata", cap_rdata, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic clear_mon();
    rd_cycles = 0; wr_cycles = 0; i_resp_cnt = 0; d_resp_cnt = 0;
    seen_addr = '0; seen_wdata = '0; cap_rdata = '0;
    resp_order.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // memory: resp in the lat-th cycle the strobe is high
  task automatic mem_serve(input int lat, input logic [LW-1:0] data);
    int t;
    t = 0;
    while (!(pmem_read || pmem_write) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!(pmem_read || pmem_write)) begin
      n_checks++;
      n_fail++;
      $display("FAIL mem_wait: no strobe after %0d cycles, required a strobe", t);
      return;
    end
    repeat (lat - 1) @(negedge clk);
    pmem_resp = 1'b1;
    pmem_rdata = data;
    exp_q.push_back(data);
    @(negedge clk);
    pmem_resp = 1'b0;
    pmem_rdata = {8{$urandom}};
  endtask

  task automatic drop_winner();
    if (resp_order.size() > 0 && resp_order[resp_order.size()-1] == 1) i_read = 1'b0;
    else begin
      d_read = 1'b0;
      d_write = 1'b0;
    end
  endtask

  task automatic sim_pair(input string nm, input int first, input int second);
    clear_mon();
    i_addr = 32'h80; d_addr = 32'h100; d_wdata = {8{$urandom}};
    i_read = 1'b1; d_read = 1'b1;
    mem_serve(2, {8{$urandom}});
    drop_winner();
    mem_serve(2, {8{$urandom}});
    i_read = 1'b0; d_read = 1'b0;
    repeat (2) @(negedge clk);
    check({nm, "_count"}, LW'(resp_order.size()), LW'(2));
    if (resp_order.size() == 2) begin
      check({nm, "_first"}, LW'(resp_order[0]), LW'(first));
      check({nm, "_second"}, LW'(resp_order[1]), LW'(second));
    end
  endtask

  initial begin
    rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = {8{$urandom}};
    clear_mon();
    do_reset();
    #2;
    check("rst_strobes", LW'({pmem_read, pmem_write, i_resp, d_resp}), '0);
    check("rst_address", LW'(pmem_address), '0);

    // I-only read, latency 3
    @(negedge clk);
    clear_mon();
    i_addr = 32'h40; i_read = 1'b1;
    mem_serve(3, {32{8'hA5}});
    i_read = 1'b0;
    repeat (2) @(negedge clk);
    check("i_rd_cycles", LW'(rd_cycles), LW'(3));
    check("i_resp_cnt", LW'(i_resp_cnt), LW'(1));
    check("i_no_d_resp", LW'(d_resp_cnt), LW'(0));
    check("i_addr", LW'(seen_addr), LW'(32'h40));
    check("i_rdata", cap_rdata, {32{8'hA5}});

    // simultaneous after reset-state last_grant: D first
    do_reset();
    sim_pair("sim1", 2, 1);

    // D address changes mid-transaction
    clear_mon();
    d_addr = 32'h100; d_read = 1'b1; d_wdata = {8{$urandom}};
    fork
      mem_serve(4, {8{$urandom}});
      begin
        repeat (2) @(negedge clk);
        d_addr = 32'h200;
        @(negedge clk);
        check("hold_addr", LW'(pmem_address), LW'(32'h100));
      end
    join
    d_read = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_d_resp", LW'(d_resp_cnt), LW'(1));
    check("hold_last_addr", LW'(seen_addr), LW'(32'h100));

    // D writeback with both strobes high
    clear_mon();
    d_addr = 32'h1000; d_wdata = {16{16'hDEAD}}; d_read = 1'b1; d_write = 1'b1;
    mem_serve(2, {8{$urandom}});
    d_read = 1'b0; d_write = 1'b0;
    repeat (2) @(negedge clk);
    check("wb_wr_cycles", LW'(wr_cycles), LW'(2));
    check("wb_rd_cycles", LW'(rd_cycles), LW'(0));
    check("wb_wdata", seen_wdata, {16{16'hDEAD}});
    check("wb_addr", LW'(seen_addr), LW'(32'h1000));
    check("wb_resp", LW'({i_resp_cnt[7:0], d_resp_cnt[7:0]}), LW'(16'h0001));

    // last grant was D: I now first
    sim_pair("sim2", 1, 2);

    // spurious resp in RECOVER
    clear_mon();
    i_addr = 32'h2C0; i_read = 1'b1;
    mem_serve(2, {8{$urandom}});
    i_read = 1'b0;
    pmem_resp = 1'b1;
    #2;
    check("rec_spur_resp", LW'({i_resp, d_resp}), '0);
    @(negedge clk);
    pmem_resp = 1'b0;
    repeat (3) @(negedge clk);
    check("rec_i_resp_cnt", LW'(i_resp_cnt), LW'(1));
    check("rec_rd_cycles", LW'(rd_cycles), LW'(2));

    // reset two cycles into SERVE_I, then a stale resp
    clear_mon();
    i_addr = 32'h300; i_read = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; i_read = 1'b0; pmem_resp = 1'b1;
    #2;
    check("rstmid_outputs", LW'({pmem_read, pmem_write, i_resp, d_resp}), '0);
    @(negedge clk);
    pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_i_resp_cnt", LW'(i_resp_cnt), LW'(0));
    check("rstmid_rd_cycles", LW'(rd_cycles), LW'(2));

    // spurious resp in IDLE
    clear_mon();
    pmem_resp = 1'b1;
    #2;
    check("idle_spur_resp", LW'({i_resp, d_resp}), '0);
    @(negedge clk);
    pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_strobe", LW'(rd_cycles + wr_cycles), LW'(0));

    check("exp_q_drained", LW'(exp_q.size()), LW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
